// File: rtl/clock_enable_ctrl.sv
// Programmable clock-enable generator: one-cycle TICK every D cycles while running,
// either continuously or for a latched burst of N ticks ending in a DONE pulse.
module clock_enable_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] burst_len,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] phase;
  logic [CNT_W-1:0] burst_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap;
  logic             last_tick;

  // The divisor register never holds 0, so div_reg-1 is always a valid wrap point.
  assign wrap      = (phase == div_reg - DIV_W'(1));
  assign cnt_next  = tick_cnt + CNT_W'(1);
  assign last_tick = (burst_reg != '0) && (cnt_next == burst_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tick_cnt  <= '0;
      phase     <= '0;
      div_reg   <= DIV_W'(1);
      burst_reg <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (div_load)
            div_reg <= (div_val == '0) ? DIV_W'(1) : div_val;
          if (start && !stop) begin
            state     <= RUN;
            busy      <= 1'b1;
            phase     <= '0;
            tick_cnt  <= '0;
            burst_reg <= burst_len;
          end
        end
        RUN: begin
          // STOP pre-empts a tick due on the same edge, including the final burst tick.
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            phase <= '0;
          end else if (wrap) begin
            phase    <= '0;
            tick     <= 1'b1;
            tick_cnt <= cnt_next;
            if (last_tick) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            phase <= phase + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Scoreboard bench: stimulus queues expected tick/done events with their edge number;
// an independent monitor pops and checks whenever the DUT pulses TICK or DONE.
module tb_clock_enable_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, div_load;
  logic [15:0] div_val;
  logic [7:0]  burst_len;
  logic        tick, busy, done;
  logic [7:0]  tick_cnt;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       done;
    logic       busy;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  s;

  clock_enable_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .div_load(div_load), .div_val(div_val), .burst_len(burst_len),
    .tick(tick), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [7:0] cnt, input logic d, input logic b);
    ev_t e;
    e.cyc = c; e.cnt = cnt; e.done = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic load_div(input logic [15:0] v);
    div_load = 1'b1; div_val = v;
    step();
    div_load = 1'b0;
  endtask

  task automatic go(input logic [7:0] n);
    start = 1'b1; burst_len = n;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (tick || done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, tick, done}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("tick_edge", cyc, e.cyc);
        chk("tick_level", tick, 1);
        chk("tick_cnt_at_tick", tick_cnt, e.cnt);
        chk("done_at_tick", done, e.done);
        chk("busy_at_tick", busy, e.busy);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_load = 1'b0;
    div_val = '0; burst_len = '0;
    step(2);
    rst = 1'b0;
    chk("reset_tick", tick, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", tick_cnt, 0);

    // Burst of 3 at divisor 4
    load_div(16'd4);
    go(8'd3);
    chk("burst_busy_after_start", busy, 1);
    chk("burst_cnt_after_start", tick_cnt, 0);
    push(s + 4, 8'd1, 1'b0, 1'b1);
    push(s + 8, 8'd2, 1'b0, 1'b1);
    push(s + 12, 8'd3, 1'b1, 1'b0);
    step(11);
    chk("burst_busy_before_last", busy, 1);
    step();
    chk("burst_busy_falls", busy, 0);
    chk("burst_done_pulse", done, 1);
    step(5);
    chk("burst_cnt_holds", tick_cnt, 3);
    chk("burst_done_one_cycle", done, 0);

    // Continuous at divisor 0 (treated as 1), 300 ticks then STOP
    load_div(16'd0);
    go(8'd0);
    for (int i = 1; i <= 300; i++) push(s + i, 8'(i), 1'b0, 1'b1);
    step(300);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("cont_tick_after_stop", tick, 0);
    chk("cont_busy_after_stop", busy, 0);
    chk("cont_cnt_wrapped", tick_cnt, 44);

    // DIV_LOAD during RUN is ignored
    load_div(16'd5);
    go(8'd0);
    push(s + 5, 8'd1, 1'b0, 1'b1);
    push(s + 10, 8'd2, 1'b0, 1'b1);
    push(s + 15, 8'd3, 1'b0, 1'b1);
    step(2);
    load_div(16'd2);
    step(12);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("divload_run_cnt", tick_cnt, 3);
    chk("divload_run_busy", busy, 0);

    // STOP on the edge of the final burst tick
    load_div(16'd3);
    go(8'd2);
    push(s + 3, 8'd1, 1'b0, 1'b1);
    step(5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_last_tick", tick, 0);
    chk("stop_last_done", done, 0);
    chk("stop_last_busy", busy, 0);
    step(4);
    chk("stop_last_cnt", tick_cnt, 1);

    // START and STOP together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    chk("start_stop_busy0", busy, 0);
    step();
    chk("start_stop_busy1", busy, 0);
    start = 1'b0; stop = 1'b0;

    // Reset mid-run at divisor 4, then divisor back to 1
    load_div(16'd4);
    go(8'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_tick", tick, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cnt", tick_cnt, 0);
    step(6);
    chk("midrst_idle_busy", busy, 0);
    go(8'd2);
    push(s + 1, 8'd1, 1'b0, 1'b1);
    push(s + 2, 8'd2, 1'b1, 1'b0);
    step(4);
    chk("post_rst_burst_cnt", tick_cnt, 2);
    chk("post_rst_busy", busy, 0);

    step(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_enable_ctrl.md
CLOCK_ENABLE_CTRL -- requirements
Module: clock_enable_ctrl

Interface
REQ-001 Parameter DIV_W, default 16, width of divisor register and phase counter.
REQ-002 Parameter CNT_W, default 8, width of burst length and tick counter.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  request to begin tick generation; sampled each edge.
REQ-006 STOP  input  1  request to abort tick generation; sampled each edge.
REQ-007 DIV_LOAD  input  1  strobe loading DIV_VAL into the divisor register.
REQ-008 DIV_VAL  input  DIV_W  tick period in CLK cycles.
REQ-009 BURST_LEN  input  CNT_W  ticks per burst; 0 = continuous; sampled on accepted START.
REQ-010 TICK  output  1  registered one-cycle clock-enable pulse.
REQ-011 BUSY  output  1  high while in RUN.
REQ-012 DONE  output  1  registered one-cycle pulse on burst completion.
REQ-013 TICK_CNT  output  CNT_W  ticks issued since last accepted START.

Function
REQ-014 States: IDLE, RUN; encoding free, no other reachable states.
REQ-015 DIV_LOAD accepted only in IDLE; ignored in RUN (divisor register unchanged).
REQ-016 Divisor value 0 treated as 1 (tick every cycle); divisor register resets to 1.
REQ-017 IDLE -> RUN on edge sampling START=1 and STOP=0; same edge: phase counter=0, TICK_CNT=0, burst length latched.
REQ-018 START in RUN ignored (no restart, counters undisturbed).
REQ-019 In RUN, phase counter increments each edge; on the edge where it equals divisor-1 it wraps to 0, TICK=1 for that cycle, TICK_CNT increments.
REQ-020 First TICK therefore rises on the D-th edge after the START-sampling edge (D = effective divisor); subsequent TICKs every D edges.
REQ-021 TICK never high in IDLE; never high on two consecutive cycles unless D=1.
REQ-022 Burst mode (latched length N>0): on the edge issuing the N-th TICK, TICK=1, DONE=1, TICK_CNT=N, state -> IDLE, BUSY=0 same edge.
REQ-023 Continuous mode (N=0): runs until STOP; TICK_CNT wraps modulo 2^CNT_W.
REQ-024 STOP=1 in RUN: next edge state -> IDLE, TICK=0, DONE=0, phase counter=0; TICK_CNT holds value.
REQ-025 START and STOP both high in IDLE: STOP wins, remain IDLE.
REQ-026 STOP on the same edge the final burst tick would issue: STOP wins, no TICK, no DONE.
REQ-027 TICK_CNT holds after burst completion until next accepted START.
REQ-028 DONE only ever high for exactly one cycle per completed burst.

Reset
REQ-029 RST=1 on an edge overrides all inputs: state=IDLE, TICK=0, BUSY=0, DONE=0, TICK_CNT=0, phase counter=0, divisor register=1, latched burst length=0.
REQ-030 RST asserted mid-RUN aborts immediately with no DONE; first edge after RST deasserts behaves as IDLE.

Verification
REQ-031 RST, DIV_LOAD DIV_VAL=4, START with BURST_LEN=3 -> TICK on edges 4, 8, 12 after START; DONE and BUSY fall on edge 12; TICK_CNT=3.
REQ-032 DIV_VAL=0, BURST_LEN=0, START -> TICK high every cycle; after 300 cycles STOP -> TICK_CNT=300 mod 256=44, TICK=0 next edge.
REQ-033 DIV_VAL=5, START, DIV_LOAD DIV_VAL=2 during RUN -> tick period stays 5.
REQ-034 DIV_VAL=3, BURST_LEN=2, STOP on edge 6 -> no second TICK, DONE never asserted, TICK_CNT=1.
REQ-035 START and STOP together in IDLE -> BUSY stays 0; RST asserted on edge 2 of a DIV=4 run -> no TICK, all outputs 0.
